// File: rtl/pd_phy_rx_deframer.sv
// Receive-path deframer: finds SOP / Hard Reset ordered sets in the 5b symbol stream,
// unpacks data symbols into a byte buffer, checks CRC-32 at EOP and hands a good message
// to the protocol layer under a ready/ack handshake.
module pd_phy_rx_deframer #(
  parameter int unsigned MAX_BYTES = 34
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_sym,
  input  logic       i_sym_valid,
  input  logic       i_rx_enable,
  output logic       o_msg_ready,
  input  logic       i_msg_ack,
  output logic [5:0] o_msg_len,
  input  logic [5:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_crc_err,
  output logic       o_hard_reset_det,
  output logic       o_rx_busy
);

  localparam logic [4:0]  SymSync1   = 5'b11000;
  localparam logic [4:0]  SymSync2   = 5'b10001;
  localparam logic [4:0]  SymRst1    = 5'b00111;
  localparam logic [4:0]  SymRst2    = 5'b11001;
  localparam logic [4:0]  SymEop     = 5'b01101;
  localparam logic [31:0] CrcPoly    = 32'h04C11DB7;
  localparam logic [31:0] CrcInit    = 32'hFFFFFFFF;
  localparam logic [31:0] CrcResidue = 32'hC704DD7B;
  localparam logic [5:0]  MaxBytesW  = 6'(MAX_BYTES);
  localparam logic [5:0]  MinBytes   = 6'd6;

  typedef enum logic [2:0] {
    StIdle,
    StOrdset,
    StPayload,
    StCheck,
    StHold,
    StDiscard
  } state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_ord_cnt, w_ord_cnt_d;
  logic [5:0]  r_byte_cnt, w_byte_cnt_d;
  logic        r_nib_phase, w_nib_phase_d;
  logic [3:0]  r_lo_nib, w_lo_nib_d;
  logic [31:0] r_crc, w_crc_d;
  logic        r_pend_good, w_pend_good;
  logic        r_pend_bad, w_pend_bad;
  logic [5:0]  r_pend_len, w_pend_len_d;
  logic        r_msg_ready, w_msg_ready_d;
  logic [5:0]  r_msg_len, w_msg_len_d;
  logic        r_crc_err, w_crc_err_d;
  logic        r_hrd;
  logic [14:0] r_hr_hist;
  logic        w_hr_match;
  logic        w_is_data;
  logic [3:0]  w_nib;
  logic        w_buf_we;
  logic [7:0]  r_buf [MAX_BYTES];

  // Four LSB-first bit steps of the MSB-first CRC register for one nibble.
  function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[31] ^ nib[i]) c = {c[30:0], 1'b0} ^ CrcPoly;
      else                c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // 4b5b data symbol decode; anything not listed is a control or invalid code.
  always_comb begin
    w_is_data = 1'b1;
    w_nib     = 4'h0;
    case (i_sym)
      5'b11110: w_nib = 4'h0;
      5'b01001: w_nib = 4'h1;
      5'b10100: w_nib = 4'h2;
      5'b10101: w_nib = 4'h3;
      5'b01010: w_nib = 4'h4;
      5'b01011: w_nib = 4'h5;
      5'b01110: w_nib = 4'h6;
      5'b01111: w_nib = 4'h7;
      5'b10010: w_nib = 4'h8;
      5'b10011: w_nib = 4'h9;
      5'b10110: w_nib = 4'hA;
      5'b10111: w_nib = 4'hB;
      5'b11010: w_nib = 4'hC;
      5'b11011: w_nib = 4'hD;
      5'b11100: w_nib = 4'hE;
      5'b11101: w_nib = 4'hF;
      default:  w_is_data = 1'b0;
    endcase
  end

  // The current symbol completes Hard Reset when the last three were all RST-1.
  assign w_hr_match = i_sym_valid && (i_sym == SymRst2) &&
                      (r_hr_hist == {SymRst1, SymRst1, SymRst1});

  // Hard Reset history runs in every state, independent of rx_enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hr_hist <= '0;
      r_hrd     <= 1'b0;
    end else begin
      r_hrd <= w_hr_match;
      if (i_sym_valid) r_hr_hist <= {r_hr_hist[9:0], i_sym};
    end
  end

  // Next-state logic for the framing FSM, payload datapath and message handshake.
  always_comb begin
    w_state_d     = r_state;
    w_ord_cnt_d   = r_ord_cnt;
    w_byte_cnt_d  = r_byte_cnt;
    w_nib_phase_d = r_nib_phase;
    w_lo_nib_d    = r_lo_nib;
    w_crc_d       = r_crc;
    w_pend_good   = 1'b0;
    w_pend_bad    = 1'b0;
    w_pend_len_d  = r_pend_len;
    w_buf_we      = 1'b0;
    // The CHECK verdict is applied one cycle after it is taken.
    w_msg_ready_d = r_msg_ready | r_pend_good;
    w_msg_len_d   = r_pend_good ? r_pend_len : r_msg_len;
    w_crc_err_d   = r_pend_bad;

    unique case (r_state)
      StIdle: begin
        if (i_rx_enable && i_sym_valid && (i_sym == SymSync1)) begin
          w_state_d   = StOrdset;
          w_ord_cnt_d = 2'd1;
        end
      end
      StOrdset: begin
        if (!i_rx_enable) begin
          w_state_d = StIdle;
        end else if (i_sym_valid) begin
          if (r_ord_cnt == 2'd3) begin
            if (i_sym == SymSync2) begin
              w_state_d     = StPayload;
              w_byte_cnt_d  = '0;
              w_nib_phase_d = 1'b0;
              w_crc_d       = CrcInit;
            end else begin
              w_state_d = StDiscard;
            end
          end else if (i_sym == SymSync1) begin
            w_ord_cnt_d = r_ord_cnt + 2'd1;
          end else begin
            w_state_d = StDiscard;
          end
        end
      end
      StPayload: begin
        if (!i_rx_enable) begin
          w_state_d = StIdle;
        end else if (i_sym_valid) begin
          if (w_is_data) begin
            w_crc_d = crc_nibble(r_crc, w_nib);
            if (!r_nib_phase) begin
              w_lo_nib_d    = w_nib;
              w_nib_phase_d = 1'b1;
            end else if (r_byte_cnt >= MaxBytesW) begin
              w_state_d = StDiscard;
            end else begin
              w_buf_we      = 1'b1;
              w_byte_cnt_d  = r_byte_cnt + 6'd1;
              w_nib_phase_d = 1'b0;
            end
          end else if (i_sym == SymEop) begin
            w_state_d = StCheck;
          end else begin
            w_state_d = StDiscard;
          end
        end
      end
      StCheck: begin
        if (!i_rx_enable) begin
          w_state_d = StIdle;
        end else if (r_nib_phase || (r_byte_cnt < MinBytes)) begin
          w_pend_bad = 1'b1;
          w_state_d  = StIdle;
        end else if (r_crc != CrcResidue) begin
          w_pend_bad = 1'b1;
          w_state_d  = StIdle;
        end else begin
          w_pend_good  = 1'b1;
          w_pend_len_d = r_byte_cnt - 6'd4;
          w_state_d    = StHold;
        end
      end
      StHold: begin
        if (r_msg_ready && i_msg_ack) begin
          w_msg_ready_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      StDiscard: begin
        if (!i_rx_enable || (i_sym_valid && (i_sym == SymEop))) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Hard Reset pre-empts everything, including a verdict in flight.
    if (w_hr_match) begin
      w_state_d     = StIdle;
      w_pend_good   = 1'b0;
      w_pend_bad    = 1'b0;
      w_msg_ready_d = 1'b0;
      w_msg_len_d   = r_msg_len;
      w_crc_err_d   = 1'b0;
    end
  end

  // State and control registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ord_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_nib_phase <= 1'b0;
      r_lo_nib    <= '0;
      r_crc       <= CrcInit;
      r_pend_good <= 1'b0;
      r_pend_bad  <= 1'b0;
      r_pend_len  <= '0;
      r_msg_ready <= 1'b0;
      r_msg_len   <= '0;
      r_crc_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ord_cnt   <= w_ord_cnt_d;
      r_byte_cnt  <= w_byte_cnt_d;
      r_nib_phase <= w_nib_phase_d;
      r_lo_nib    <= w_lo_nib_d;
      r_crc       <= w_crc_d;
      r_pend_good <= w_pend_good;
      r_pend_bad  <= w_pend_bad;
      r_pend_len  <= w_pend_len_d;
      r_msg_ready <= w_msg_ready_d;
      r_msg_len   <= w_msg_len_d;
      r_crc_err   <= w_crc_err_d;
    end
  end

  // Message buffer: written only from PAYLOAD, never reset.
  always_ff @(posedge i_clk) begin
    if (w_buf_we) r_buf[r_byte_cnt] <= {w_nib, r_lo_nib};
  end

  // Combinational read port; out-of-range addresses read as zero.
  always_comb begin
    o_rd_data = 8'h00;
    if (i_rd_addr < MaxBytesW) o_rd_data = r_buf[i_rd_addr];
  end

  assign o_msg_ready      = r_msg_ready;
  assign o_msg_len        = r_msg_len;
  assign o_crc_err        = r_crc_err;
  assign o_hard_reset_det = r_hrd;
  assign o_rx_busy        = (r_state == StOrdset) || (r_state == StPayload) ||
                            (r_state == StCheck)  || (r_state == StDiscard);

endmodule

// File: tb/tb_pd_phy_rx_deframer.sv
// Bench for pd_phy_rx_deframer: frame-level reference model plus directed scenarios.
module tb_pd_phy_rx_deframer;

  localparam int unsigned MaxBytes = 34;
  localparam logic [4:0] S1  = 5'b11000;
  localparam logic [4:0] S2  = 5'b10001;
  localparam logic [4:0] R1  = 5'b00111;
  localparam logic [4:0] R2  = 5'b11001;
  localparam logic [4:0] EOP = 5'b01101;
  localparam logic [4:0] CODE [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};

  typedef logic [7:0] byte_q_t [$];
  typedef logic [4:0] sym_q_t [$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sym = 5'b0;
  logic       sym_valid = 1'b0;
  logic       rx_enable = 1'b1;
  logic       msg_ack = 1'b0;
  logic [5:0] rd_addr = 6'd0;
  logic       msg_ready, crc_err, hard_reset_det, rx_busy;
  logic [5:0] msg_len;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  pd_phy_rx_deframer #(.MAX_BYTES(MaxBytes)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_sym            (sym),
    .i_sym_valid      (sym_valid),
    .i_rx_enable      (rx_enable),
    .o_msg_ready      (msg_ready),
    .i_msg_ack        (msg_ack),
    .o_msg_len        (msg_len),
    .i_rd_addr        (rd_addr),
    .o_rd_data        (rd_data),
    .o_crc_err        (crc_err),
    .o_hard_reset_det (hard_reset_det),
    .o_rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reflected CRC-32 without final inversion; a frame with its CRC appended leaves DEBB20E3.
  function automatic logic [31:0] crc_raw(input byte_q_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] crc32(input byte_q_t q);
    return ~crc_raw(q);
  endfunction

  function automatic int code_index(input logic [4:0] s);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++) if (CODE[i] == s) r = i;
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic [4:0] m_hist [3];
  sym_q_t     m_frame;
  bit         m_in_frame, m_junk, m_chk, m_due, m_holding;
  int         m_outcome;   // 0 silent, 1 good, 2 bad
  logic [5:0] m_pend_len;
  logic [7:0] m_buf [64];
  int         m_nbytes;
  logic       exp_ready, exp_err, exp_hrd;
  logic [5:0] exp_len;

  task automatic model_eval();
    int n, nb;
    byte_q_t bytes;
    n  = m_frame.size() - 4;
    nb = n / 2;
    for (int i = 0; i < nb; i++)
      bytes.push_back({4'(code_index(m_frame[4 + 2*i + 1])), 4'(code_index(m_frame[4 + 2*i]))});
    if (nb > int'(MaxBytes)) begin
      m_outcome = 0;
    end else begin
      m_chk = 1'b1;
      if ((n % 2) != 0 || nb < 6)                m_outcome = 2;
      else if (crc_raw(bytes) != 32'hDEBB20E3)    m_outcome = 2;
      else begin
        m_outcome  = 1;
        m_pend_len = 6'(nb - 4);
        m_nbytes   = nb;
        for (int i = 0; i < nb; i++) m_buf[i] = bytes[i];
      end
    end
  endtask

  task automatic model_symbol(input logic [4:0] s);
    if (!m_in_frame) begin
      if (s == S1) begin
        m_in_frame = 1'b1;
        m_junk     = 1'b0;
        m_frame    = {s};
      end
    end else if (m_junk) begin
      if (s == EOP) m_in_frame = 1'b0;
    end else if (m_frame.size() < 4) begin
      if (s != ((m_frame.size() == 3) ? S2 : S1)) m_junk = 1'b1;
      else m_frame.push_back(s);
    end else if (s == EOP) begin
      m_in_frame = 1'b0;
      model_eval();
    end else if (code_index(s) >= 0) begin
      m_frame.push_back(s);
    end else begin
      m_junk = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit         hr;
    logic [5:0] old_len;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_hist[i] = 5'b0;
      m_in_frame = 0; m_junk = 0; m_chk = 0; m_due = 0; m_holding = 0; m_outcome = 0;
      exp_ready = 0; exp_err = 0; exp_hrd = 0; exp_len = 6'd0;
    end else begin
      hr = sym_valid && sym == R2 && m_hist[0] == R1 && m_hist[1] == R1 && m_hist[2] == R1;
      if (sym_valid) begin
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = sym;
      end
      old_len = exp_len;
      exp_hrd = hr;
      exp_err = 1'b0;
      if (m_holding && exp_ready && msg_ack) begin
        exp_ready = 1'b0;
        m_holding = 1'b0;
      end
      if (m_due) begin
        m_due = 1'b0;
        if (m_outcome == 1) begin
          exp_ready = 1'b1;
          exp_len   = m_pend_len;
        end else if (m_outcome == 2) begin
          exp_err = 1'b1;
        end
      end
      if (m_chk) begin
        m_chk = 1'b0;
        if (rx_enable) begin
          m_due = 1'b1;
          if (m_outcome == 1) m_holding = 1'b1;
        end
      end else if (!m_holding) begin
        if (m_in_frame && !rx_enable) m_in_frame = 1'b0;
        else if (sym_valid && (m_in_frame || rx_enable)) model_symbol(sym);
      end
      if (hr) begin
        m_in_frame = 0; m_chk = 0; m_due = 0; m_holding = 0;
        exp_ready = 0; exp_err = 0; exp_len = old_len;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("cmp_msg_ready", msg_ready, exp_ready);
      check("cmp_crc_err", crc_err, exp_err);
      check("cmp_hard_reset_det", hard_reset_det, exp_hrd);
      check("cmp_rx_busy", rx_busy, m_in_frame || m_chk);
      check("cmp_msg_len", msg_len, exp_len);
      if (exp_ready && int'(rd_addr) < m_nbytes) check("cmp_rd_data", rd_data, m_buf[rd_addr]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] s);
    sym       = s;
    sym_valid = 1'b1;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send(CODE[b[3:0]]);
    send(CODE[b[7:4]]);
  endtask

  task automatic send_sop();
    send(S1); send(S1); send(S1); send(S2);
  endtask

  task automatic send_hr();
    send(R1); send(R1); send(R1); send(R2);
  endtask

  // Sends SOP, payload, CRC (optionally with one bit flipped) and EOP.
  task automatic send_msg(input byte_q_t q, input int flip);
    logic [31:0] c;
    logic [7:0]  t;
    byte_q_t     f;
    c = crc32(q);
    f = q;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    if (flip >= 0) begin
      t = f[flip / 8];
      t[flip % 8] = ~t[flip % 8];
      f[flip / 8] = t;
    end
    send_sop();
    foreach (f[i]) send_byte(f[i]);
    send(EOP);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, msg_ready, 1'b0);
    check({tag, "_err"}, crc_err, 1'b0);
    check({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_q_t q9, hdr, big, f;
    logic [31:0] c;

    #12;
    check("rst_ready", msg_ready, 1'b0);
    check("rst_len", msg_len, 6'd0);
    check("rst_err", crc_err, 1'b0);
    check("rst_hrd", hard_reset_det, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    @(posedge clk); #1;
    rst_n   = 1'b1;
    run_cmp = 1'b1;
    tick(2);

    // Pin the CRC model to well-known values.
    q9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_pin_123456789", crc32(q9), 32'hCBF43926);
    hdr = {8'h41, 8'h00};
    c = crc32(hdr);
    f = hdr;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    check("crc_pin_residue", crc_raw(f), 32'hDEBB20E3);

    // Good message.
    send_msg(hdr, -1);
    check("good_check_busy", rx_busy, 1'b1);
    tick(1);
    check("good_ready_k1", msg_ready, 1'b0);
    tick(1);
    check("good_ready_k2", msg_ready, 1'b1);
    check("good_len", msg_len, 6'd2);
    rd_addr = 6'd0; #1;
    check("good_rd0", rd_data, 8'h41);
    rd_addr = 6'd1; #1;
    check("good_rd1", rd_data, 8'h00);
    msg_ack = 1'b1;
    tick(1);
    msg_ack = 1'b0;
    check("ack_clears_ready", msg_ready, 1'b0);
    tick(1);

    // Corrupted CRC.
    send_msg(hdr, 5);
    tick(1);
    check("bad_err_k1", crc_err, 1'b0);
    tick(1);
    check("bad_err_k2", crc_err, 1'b1);
    check("bad_ready", msg_ready, 1'b0);
    tick(1);
    check_idle_outputs("bad_after");

    // Hard Reset mid-payload.
    send_sop(); send_byte(8'h12); send_byte(8'h34);
    send_hr();
    check("hr_pay_pulse", hard_reset_det, 1'b1);
    check("hr_pay_busy", rx_busy, 1'b0);
    tick(1);
    check("hr_pay_pulse_end", hard_reset_det, 1'b0);

    // Hard Reset while holding a message.
    send_msg(hdr, -1);
    tick(2);
    check("hr_hold_pre", msg_ready, 1'b1);
    send_hr();
    check("hr_hold_pulse", hard_reset_det, 1'b1);
    check("hr_hold_ready", msg_ready, 1'b0);
    tick(1);

    // Following message is received normally; sweep the read port.
    send_msg({8'h61, 8'h12, 8'h34, 8'h56, 8'h78}, -1);
    tick(2);
    check("post_hr_ready", msg_ready, 1'b1);
    check("post_hr_len", msg_len, 6'd5);
    for (int a = 0; a < 10; a++) begin
      rd_addr = 6'(a);
      tick(1);
    end
    msg_ack = 1'b1; tick(1); msg_ack = 1'b0;

    // Overlength payload: silently discarded.
    send_sop();
    for (int i = 0; i < 35; i++) send_byte(8'(i * 7));
    send(EOP);
    check("ovl_busy_after_eop", rx_busy, 1'b0);
    tick(2);
    check_idle_outputs("ovl");

    // Bad ordered set.
    send(S1); send(S1); send(S2); send(S2); send(CODE[3]); send(EOP);
    check("bados_busy_after_eop", rx_busy, 1'b0);
    tick(2);
    check_idle_outputs("bados");

    send_msg({8'hA5, 8'h5A, 8'hFF, 8'h00}, -1);
    tick(2);
    check("recover_ready", msg_ready, 1'b1);
    check("recover_len", msg_len, 6'd4);
    msg_ack = 1'b1; tick(1); msg_ack = 1'b0;

    // Runt: 5 bytes.
    send_sop();
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
    send(EOP);
    tick(2);
    check("runt_err", crc_err, 1'b1);
    check("runt_ready", msg_ready, 1'b0);
    tick(1);

    // Odd nibble count: 13 nibbles.
    send_sop();
    for (int i = 0; i < 13; i++) send(CODE[i]);
    send(EOP);
    tick(2);
    check("odd_err", crc_err, 1'b1);
    check("odd_ready", msg_ready, 1'b0);
    tick(1);

    // Async reset mid-payload.
    send_sop(); send_byte(8'h11); send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pay_busy", rx_busy, 1'b0);
    check("arst_pay_len", msg_len, 6'd0);
    check("arst_pay_ready", msg_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // Async reset while holding.
    send_msg(hdr, -1);
    tick(2);
    check("arst_hold_pre", msg_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold_ready", msg_ready, 1'b0);
    check("arst_hold_len", msg_len, 6'd0);
    check("arst_hold_hrd", hard_reset_det, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);

    // rx_enable low mid-payload: back to idle on the next edge.
    send_sop(); send_byte(8'h33);
    rx_enable = 1'b0;
    tick(1);
    check("rxen_pay_busy", rx_busy, 1'b0);
    rx_enable = 1'b1;
    send_byte(8'h44); send(EOP);
    tick(2);
    check_idle_outputs("rxen_pay");

    // rx_enable low while holding: message retained.
    send_msg(hdr, -1);
    tick(2);
    rx_enable = 1'b0;
    tick(3);
    check("rxen_hold_ready", msg_ready, 1'b1);
    rx_enable = 1'b1;

    // Hard Reset coinciding with msg_ack.
    send(R1); send(R1); send(R1);
    msg_ack = 1'b1;
    send(R2);
    msg_ack = 1'b0;
    check("hr_ack_pulse", hard_reset_det, 1'b1);
    check("hr_ack_ready", msg_ready, 1'b0);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pd_phy_rx_deframer.md
# pd_phy_rx_deframer

Receive-path deframer between the BMC/4b5b line decoder and the protocol-layer Rx state machine.
- Detects the SOP and Hard Reset ordered sets in the 5b symbol stream.
- Decodes data symbols into bytes and stores header, data objects and CRC in a local buffer.
- Checks CRC-32 at EOP and presents a good message to the protocol layer under a ready/ack handshake.
- Its `hard_reset_det` pulse feeds the protocol layer's `PHY_Reset` input.

## Interface
- MAX_BYTES, 34: buffer depth in bytes, including the 4 CRC bytes (2 header + 28 data + 4 CRC).
- CLK  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- sym_in  input  5  5b symbol, code bits written MSB..LSB as listed under Operation.
- sym_valid  input  1  sym_in is valid this cycle; at most one symbol per cycle.
- rx_enable  input  1  0 aborts or blocks reception (HOLD excepted).
- msg_ready  output  1  a good message is in the buffer; held until acknowledged.
- msg_ack  input  1  protocol layer has consumed the message.
- msg_len  output  6  header+data byte count, excluding CRC; valid while msg_ready=1.
- rd_addr  input  6  buffer read address; byte 0 is the header LSB.
- rd_data  output  8  buffer[rd_addr], combinational read.
- crc_err  output  1  one-cycle pulse: EOP reached with bad CRC or bad length.
- hard_reset_det  output  1  one-cycle pulse: Hard Reset ordered set seen.
- rx_busy  output  1  high in ORDSET, PAYLOAD, CHECK, DISCARD.

## Operation
- Data symbol codes 0x0..0xF:
  - 0x0–0x7: 11110, 01001, 10100, 10101, 01010, 01011, 01110, 01111
  - 0x8–0xF: 10010, 10011, 10110, 10111, 11010, 11011, 11100, 11101
- Control codes: Sync-1 11000, Sync-2 10001, RST-1 00111, RST-2 11001, EOP 01101. All other codes are invalid.
- SOP = Sync-1, Sync-1, Sync-1, Sync-2; all four must match exactly. Hard Reset = RST-1, RST-1, RST-1, RST-2.
- Hard Reset detector:
  - Independent 4-deep shift register of valid symbols, active in every state regardless of rx_enable.
  - On match: pulse hard_reset_det, force IDLE, clear msg_ready.
- FSM states: IDLE, ORDSET, PAYLOAD, CHECK, HOLD, DISCARD.
  - IDLE: a Sync-1 starts ORDSET (symbol count 1); any other symbol is ignored.
  - ORDSET: collect symbols 2–4. Full SOP match → PAYLOAD, with byte count 0, nibble phase 0 and CRC 0xFFFFFFFF. Mismatch at any position → DISCARD.
  - PAYLOAD handling of each valid symbol:
    - Data symbol: low nibble first, then high nibble; the byte is written at the byte count, which then increments. CRC updates on every nibble.
    - EOP: → CHECK.
    - Invalid or control symbol: → DISCARD.
    - Write when byte count = MAX_BYTES: → DISCARD.
  - CHECK (one cycle), evaluated in this order:
    - Odd nibble count or byte count < 6: crc_err pulse, → IDLE.
    - CRC register ≠ residue 0xC704DD7B: crc_err pulse, → IDLE.
    - Otherwise: msg_len = byte count − 4, msg_ready = 1, → HOLD.
  - HOLD: incoming symbols ignored. msg_ack=1 → msg_ready=0, → IDLE. msg_ack in any other state is ignored.
  - DISCARD: wait for EOP → IDLE. No crc_err, no msg_ready.
- rx_enable=0 sends ORDSET, PAYLOAD, CHECK and DISCARD to IDLE on the next edge and blocks leaving IDLE. HOLD is unaffected.
- CRC-32:
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF.
  - Bits processed LSB-first, 4 bit-steps per nibble in one cycle.
  - Runs over all bytes including the received CRC, so a good message leaves the residue.
- Buffer writes occur only in PAYLOAD. Buffer contents are not reset. msg_len holds its value until the next successful CHECK.

## Timing
- Reset values: msg_ready 0, msg_len 0, crc_err 0, hard_reset_det 0, rx_busy 0, FSM IDLE, CRC 0xFFFFFFFF, shift register cleared.
- Async reset asserted mid-message or in HOLD zeroes all outputs immediately, without waiting for a clock edge.
- EOP sampled at edge k: CHECK during cycle k..k+1; msg_ready or crc_err high from edge k+2. crc_err lasts exactly one cycle.
- The 4th Hard Reset symbol sampled at edge k: hard_reset_det high for cycle k..k+1, FSM IDLE from edge k.
- Hard Reset match coinciding with EOP or msg_ack: Hard Reset wins; no msg_ready, no crc_err.
- msg_ack sampled at edge k: msg_ready low from edge k. An SOP may start at edge k+1.
- rd_data follows rd_addr in the same cycle.

## Test plan
- Good message:
  - Stimulus: SOP, header bytes 0x41 0x00, correct CRC bytes from the bench model, EOP.
  - Response: msg_ready at EOP edge+2, msg_len=2, rd_data@0=0x41, rd_data@1=0x00.
  - Then msg_ack=1: msg_ready low next edge.
- Corrupted CRC:
  - Stimulus: same message with one CRC bit flipped.
  - Response: crc_err single pulse at EOP+2, msg_ready stays 0, rx_busy 0 afterwards.
- Hard Reset preemption:
  - Stimulus: RST-1×3, RST-2 injected mid-PAYLOAD, and again while in HOLD.
  - Response: hard_reset_det one-cycle pulse, msg_ready cleared. The following good SOP message is received normally.
- Overlength and bad ordered set:
  - Stimulus: 35-byte payload; separately, Sync-1, Sync-1, Sync-2, Sync-2, data, EOP.
  - Response: no msg_ready, no crc_err, rx_busy drops after EOP. The next good message succeeds.
- Runt and odd length:
  - Stimulus: 5 bytes, then EOP; separately, 13 nibbles, then EOP.
  - Response: crc_err pulse in each case, msg_ready 0.
- Async reset and rx_enable:
  - Stimulus: reset low mid-PAYLOAD and in HOLD; separately, rx_enable=0 mid-PAYLOAD and rx_enable=0 during HOLD.
  - Response:
    - Reset: all outputs 0 immediately.
    - rx_enable=0 mid-PAYLOAD: IDLE next edge.
    - rx_enable=0 during HOLD: msg_ready retained.
